// File: rtl/ysyx_l1i_cache.sv
// ysyx_l1i_cache: direct-mapped L1 instruction cache, same-cycle hit, word-by-word line refill
module ysyx_l1i_cache #(
  parameter int XLEN = 32,
  parameter int L1I_LEN = 4,
  parameter int L1I_LINE_LEN = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] ifu_pc,
  input  logic            ifu_invalid,
  output logic [31:0]     ifu_inst,
  output logic            ifu_valid,
  output logic            mem_arvalid,
  output logic [XLEN-1:0] mem_araddr,
  input  logic            mem_arready,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic            mem_rready
);
  localparam int OW = L1I_LINE_LEN - 2;
  localparam int TW = XLEN - L1I_LEN - L1I_LINE_LEN;
  localparam int LINES = 1 << L1I_LEN;
  localparam int WORDS = 1 << OW;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_d;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [31:0] data [LINES][WORDS];
  logic [TW-1:0] tag_l;
  logic [L1I_LEN-1:0] idx_l;
  logic [OW-1:0] cnt;
  logic kill;
  logic [OW-1:0] off;
  logic [L1I_LEN-1:0] idx;
  logic [TW-1:0] tag;
  logic hit, miss_go, beat, last, unused_ok;
  assign off = ifu_pc[L1I_LINE_LEN-1:2];
  assign idx = ifu_pc[L1I_LINE_LEN+L1I_LEN-1:L1I_LINE_LEN];
  assign tag = ifu_pc[XLEN-1 -: TW];
  assign unused_ok = ^ifu_pc[1:0];
  assign hit = valid[idx] && tags[idx] == tag;
  assign miss_go = state == IDLE && !hit && !ifu_invalid;
  assign beat = state == WAIT && mem_rvalid;
  assign last = &cnt;
  assign ifu_valid = state == IDLE && hit && !ifu_invalid;
  assign ifu_inst = data[idx][off];
  assign mem_arvalid = state == REQ;
  assign mem_rready = state == WAIT;
  assign mem_araddr = {tag_l, idx_l, cnt, 2'b00};
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (miss_go ? REQ : IDLE)
            : state == REQ  ? (mem_arready ? WAIT : REQ)
            : (mem_rvalid ? (last ? IDLE : REQ) : WAIT);
  end
  // a line being drained when fence.i arrives is marked killed so it never becomes valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      valid <= '0;
      tag_l <= '0;
      idx_l <= '0;
      cnt <= '0;
      kill <= 1'b0;
    end else begin
      state <= state_d;
      if (miss_go) begin
        tag_l <= tag;
        idx_l <= idx;
        cnt <= '0;
        kill <= 1'b0;
      end else if (beat) cnt <= cnt + 1'b1;
      if (ifu_invalid && state != IDLE) kill <= 1'b1;
      if (ifu_invalid) valid <= '0;
      else if (beat && last && !kill) valid[idx_l] <= 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (beat) begin
      data[idx_l][cnt] <= mem_rdata;
      if (last) tags[idx_l] <= tag_l;
    end
  end
endmodule

// File: tb/tb_ysyx_l1i_cache.sv
// tb_ysyx_l1i_cache: randomized fetch stream against a line-level cache model, scoreboarded
module tb_ysyx_l1i_cache;
  logic clock = 0, reset = 0;
  logic [31:0] ifu_pc = 0;
  logic ifu_invalid = 1;
  logic [31:0] ifu_inst;
  logic ifu_valid, mem_arvalid, mem_rready;
  logic [31:0] mem_araddr;
  logic mem_arready = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;

  ysyx_l1i_cache dut (
    .clock(clock), .reset(reset), .ifu_pc(ifu_pc), .ifu_invalid(ifu_invalid),
    .ifu_inst(ifu_inst), .ifu_valid(ifu_valid), .mem_arvalid(mem_arvalid),
    .mem_araddr(mem_araddr), .mem_arready(mem_arready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rready(mem_rready)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, beats = 0, stall_n = 0, dly = 0;
  logic req = 0, pend = 0, pw = 0;
  logic [31:0] pa = 0, paddr = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ar_q[$];
  logic v_m [16];
  logic [23:0] t_m [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h8000000) return 32'h11 * (32'(a[3:2]) + 32'd1);
    return (a * 32'h9E3779B1) ^ 32'h5bd1e995;
  endfunction

  function automatic logic model_hit(input logic [31:0] pc);
    return v_m[pc[7:4]] && t_m[pc[7:4]] == pc[31:8];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) v_m[i] = 0;
  endtask

  task automatic expect_fill(input logic [31:0] pc);
    for (int k = 0; k < 4; k++) ar_q.push_back({pc[31:4], 2'(k), 2'b00});
    v_m[pc[7:4]] = 1;
    t_m[pc[7:4]] = pc[31:8];
  endtask

  task automatic await_hit(input logic [31:0] pc);
    exp_q.push_back(mem_word({pc[31:2], 2'b00}));
    req = 1;
    for (int i = 0; i < 400 && req; i++) @(negedge clock);
    total++;
    if (req) begin
      bad++;
      $display("FAIL fetch_timeout: pc %h got no ifu_valid want ifu_valid within 400 cycles", pc);
      req = 0;
      exp_q.delete();
    end
  endtask

  task automatic fetch(input logic [31:0] pc);
    logic h;
    h = model_hit(pc);
    if (!h) expect_fill(pc);
    ifu_pc = pc;
    #1;
    chk("hit_same_cycle", ifu_valid, h);
    if (h) chk("no_ar_on_hit", mem_arvalid, 0);
    await_hit(pc);
  endtask

  task automatic inv();
    ifu_invalid = 1;
    #1;
    chk("inv_blocks_valid", ifu_valid, 0);
    @(negedge clock);
    ifu_invalid = 0;
    model_clear();
    expect_fill(ifu_pc);
    await_hit(ifu_pc);
  endtask

  task automatic fetch_inv(input logic [31:0] pc);
    int b0;
    logic got;
    got = 0;
    b0 = beats;
    expect_fill(pc);
    ifu_pc = pc;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      #1;
      got = beats >= b0 + 2;
    end
    chk("second_beat_seen", got, 1);
    ifu_invalid = 1;
    @(negedge clock);
    ifu_invalid = 0;
    model_clear();
    expect_fill(pc);
    await_hit(pc);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [23:0] t;
    case ($urandom_range(0, 2))
      0: t = 24'h800000;
      1: t = 24'h800001;
      default: t = 24'h3000ab;
    endcase
    return {t, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
  endfunction

  // memory side: random AR acceptance and R latency, one read outstanding
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        pend = 0;
        pw = 0;
        ar_q.delete();
        mem_arready = 0;
        mem_rvalid = 1;
        mem_rdata = 32'hdead_beef;
      end else begin
        mem_arready = 0;
        mem_rvalid = 0;
        chk("rready_iff_outstanding", mem_rready, pend);
        if (pend) chk("no_ar_while_outstanding", mem_arvalid, 0);
        if (pw) begin
          chk("arvalid_held", mem_arvalid, 1);
          chk("araddr_held", mem_araddr, pa);
        end
        pw = 0;
        if (pend) begin
          if (dly == 0) begin
            mem_rvalid = 1;
            mem_rdata = mem_word(paddr);
            pend = 0;
            beats++;
          end else dly--;
        end else if (mem_arvalid) begin
          if (stall_n > 0) begin
            stall_n--;
            pw = 1;
            pa = mem_araddr;
            if (ar_q.size() > 0) chk("stall_araddr", mem_araddr, ar_q[0]);
          end else if ($urandom_range(0, 3) == 0) begin
            pw = 1;
            pa = mem_araddr;
          end else begin
            mem_arready = 1;
            if (ar_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL araddr: got request %h want none", mem_araddr);
            end else chk("araddr", mem_araddr, ar_q.pop_front());
            pend = 1;
            paddr = mem_araddr;
            dly = $urandom_range(0, 2);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (req && ifu_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL inst: got %h want nothing queued", ifu_inst);
        end else chk("inst", ifu_inst, exp_q.pop_front());
        req = 0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish want finish before 800us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    model_clear();
    @(negedge clock);
    #1;
    chk("rst_arvalid", mem_arvalid, 0);
    chk("rst_rready", mem_rready, 0);
    chk("rst_ifu_valid", ifu_valid, 0);
    @(negedge clock);
    #3 reset = 1;
    @(negedge clock);
    ifu_invalid = 0;
    fetch(32'h8000_0000);
    fetch(32'h8000_0008);
    fetch(32'h8000_0100);
    fetch(32'h8000_0000);
    fetch_inv(32'h8000_0040);
    stall_n = 5;
    fetch(32'h8000_0280);
    fetch(32'h8000_0284);
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) inv();
      else fetch(rand_pc());
    end
    p = 32'h7777_7730;
    expect_fill(p);
    ifu_pc = p;
    for (int i = 0; i < 100 && !mem_rready; i++) begin
      @(negedge clock);
      #1;
    end
    chk("reached_wait", mem_rready, 1);
    #2 reset = 0;
    #1;
    chk("rst_mid_arvalid", mem_arvalid, 0);
    chk("rst_mid_rready", mem_rready, 0);
    chk("rst_mid_ifu_valid", ifu_valid, 0);
    @(negedge clock);
    @(negedge clock);
    model_clear();
    #3 reset = 1;
    expect_fill(p);
    #1;
    chk("post_rst_miss", ifu_valid, 0);
    await_hit(p);
    fetch(32'h8000_0008);
    fetch(32'h8000_0008);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("ar_q_drained", ar_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
